flr_sequencer: RTL and testbench

Serializes PCIe Function Level Reset handling for the four physical functions. It detects new FLR requests on `cfg_flr_in_process`, and grants one function at a time round-robin access to the shared user-side drain and reset engine. It holds that function's user logic in reset, then returns the one-cycle `cfg_flr_done` pulse to the PCIe core. It sits between the core's cfg interface and the per-function DMA/user logic.

---
 rtl/flr_sequencer.sv | 125 ++++++++++++
 tb/tb_flr_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flr_sequencer.sv
// Serializes PCIe Function Level Reset across four physical functions: round-robin
// grant, drain via the shared engine, hold the function's user reset, then return done.
module flr_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RESET_HOLD     = 16
) (
  input  logic       user_clk,
  input  logic       user_reset,
  input  logic [3:0] cfg_flr_in_process,
  output logic [3:0] cfg_flr_done,
  output logic       drain_req,
  output logic [1:0] drain_fn,
  input  logic       drain_ack,
  output logic [3:0] fn_reset,
  output logic [3:0] flr_timeout,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > RESET_HOLD) ? TIMEOUT_CYCLES : RESET_HOLD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_RESET = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    sel;
  logic [1:0]    rr;
  logic [CW-1:0] cnt;
  logic [3:0]    prev;
  logic [3:0]    pending;
  logic [3:0]    pending_nxt;
  logic [3:0]    rise;
  logic [3:0]    sel_mask;
  logic [3:0]    grant_mask;
  logic [3:0]    abort_mask;
  logic          grant_found;
  logic [1:0]    grant_fn;
  logic [1:0]    idx;

  // Round-robin search starting at rr, wrapping mod 4.
  always_comb begin
    grant_found = 1'b0;
    grant_fn    = rr;
    idx         = rr;
    for (int k = 0; k < 4; k++) begin
      idx = rr + 2'(k);
      if (!grant_found && pending[idx]) begin
        grant_found = 1'b1;
        grant_fn    = idx;
      end
    end
  end

  assign rise       = cfg_flr_in_process & ~prev;
  assign sel_mask   = 4'b0001 << sel;
  assign busy       = (state != ST_IDLE);
  assign grant_mask = (state == ST_IDLE && grant_found) ? (4'b0001 << grant_fn) : 4'b0000;
  assign abort_mask = ~cfg_flr_in_process & ~(busy ? sel_mask : 4'b0000);

  // The request is consumed at grant, so an in-process fall and re-rise during the
  // function's own sequence leaves it queued and it is served again afterwards.
  assign pending_nxt = (pending & ~abort_mask & ~grant_mask) | rise;

  // drain_req is held high for the whole DRAIN state; drain_ack is only observed
  // while drain_req is high, and an ack on the final timeout cycle counts as an ack.
  assign drain_req    = (state == ST_DRAIN);
  assign drain_fn     = busy ? sel : 2'd0;
  assign fn_reset     = (state == ST_RESET) ? sel_mask : 4'b0000;
  assign cfg_flr_done = (state == ST_DONE) ? (sel_mask & cfg_flr_in_process) : 4'b0000;
  assign state_dbg    = state;

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state       <= ST_IDLE;
      sel         <= 2'd0;
      rr          <= 2'd0;
      cnt         <= '0;
      prev        <= 4'b0000;
      pending     <= 4'b0000;
      flr_timeout <= 4'b0000;
    end else begin
      prev    <= cfg_flr_in_process;
      pending <= pending_nxt;
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            sel   <= grant_fn;
            rr    <= grant_fn + 2'd1;
            cnt   <= '0;
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_ack) begin
            cnt   <= '0;
            state <= ST_RESET;
          end else if (cnt == TO_LAST) begin
            flr_timeout <= flr_timeout | sel_mask;
            cnt         <= '0;
            state       <= ST_RESET;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESET: begin
          if (cnt == HOLD_LAST) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flr_sequencer.sv
// Directed bench for flr_sequencer: a timestamp-based request/sequence model checked
// every cycle, plus literal expectations for each scenario.
module tb_flr_sequencer;

  localparam int TO   = 8;
  localparam int HOLD = 16;

  logic       user_clk = 1'b0;
  logic       user_reset;
  logic [3:0] cfg_flr_in_process;
  logic [3:0] cfg_flr_done;
  logic       drain_req;
  logic [1:0] drain_fn;
  logic       drain_ack;
  logic [3:0] fn_reset;
  logic [3:0] flr_timeout;
  logic       busy;
  logic [1:0] state_dbg;

  flr_sequencer #(.TIMEOUT_CYCLES(TO), .RESET_HOLD(HOLD)) dut (
    .user_clk           (user_clk),
    .user_reset         (user_reset),
    .cfg_flr_in_process (cfg_flr_in_process),
    .cfg_flr_done       (cfg_flr_done),
    .drain_req          (drain_req),
    .drain_fn           (drain_fn),
    .drain_ack          (drain_ack),
    .fn_reset           (fn_reset),
    .flr_timeout        (flr_timeout),
    .busy               (busy),
    .state_dbg          (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 user_clk = ~user_clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A job is described by the edge it was granted at and the edge its drain ended;
  // every output is derived from the current edge count relative to those stamps.
  int         e = 0;
  bit         m_job = 1'b0;
  int         m_fn = 0;
  int         m_start = 0;
  int         m_end = 0;
  bit         m_ended = 1'b0;
  int         m_rr = 0;
  logic [3:0] m_prev = 4'b0;
  logic [3:0] m_pend = 4'b0;
  logic [3:0] m_to = 4'b0;

  always @(posedge user_clk) begin
    logic [3:0] cur;
    logic [3:0] rs;
    int         grant;
    bit         was_job;
    e++;
    if (user_reset) begin
      m_job = 1'b0; m_rr = 0; m_prev = 4'b0; m_pend = 4'b0; m_to = 4'b0;
    end else begin
      cur     = cfg_flr_in_process;
      rs      = cur & ~m_prev;
      was_job = m_job;
      grant   = -1;
      if (m_job) begin
        if (!m_ended) begin
          if (drain_ack) begin
            m_end = e; m_ended = 1'b1;
          end else if (e - m_start == TO) begin
            m_to[m_fn] = 1'b1; m_end = e; m_ended = 1'b1;
          end
        end else if (e == m_end + HOLD + 1) begin
          m_job = 1'b0;
        end
      end else begin
        for (int k = 0; k < 4; k++)
          if (grant < 0 && m_pend[(m_rr + k) % 4]) grant = (m_rr + k) % 4;
        if (grant >= 0) begin
          m_job = 1'b1; m_fn = grant; m_start = e; m_ended = 1'b0; m_rr = (grant + 1) % 4;
        end
      end
      for (int i = 0; i < 4; i++)
        if (!cur[i] && !(was_job && m_fn == i)) m_pend[i] = 1'b0;
      if (grant >= 0) m_pend[grant] = 1'b0;
      m_pend = m_pend | rs;
      m_prev = cur;
    end
  end

  always @(negedge user_clk) begin
    logic [3:0]  e_rst;
    logic [3:0]  e_done;
    logic [15:0] exp_v;
    logic [15:0] got_v;
    if (check_en) begin
      e_rst  = 4'b0;
      e_done = 4'b0;
      if (m_job && m_ended && e < m_end + HOLD) e_rst = 4'b0001 << m_fn;
      if (m_job && m_ended && e == m_end + HOLD) e_done = (4'b0001 << m_fn) & cfg_flr_in_process;
      exp_v = {m_job, m_job && !m_ended, (m_job ? 2'(m_fn) : 2'd0), e_rst, e_done, m_to};
      got_v = {busy, drain_req, drain_fn, fn_reset, cfg_flr_done, flr_timeout};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL model_cmp edge=%0d got=%h exp=%h", e, got_v, exp_v);
      end
    end
  end

  // ---------------- driver tasks / scoreboard ----------------
  int         ack_delay = 0;
  int         run = 0;
  int         last_run = 0;
  bit         prev_dr = 1'b0;
  bit         multi = 1'b0;
  int         done_cnt[4];
  logic [1:0] got_q[$];
  logic [1:0] exp_q[$];

  task automatic step();
    @(posedge user_clk);
    #1;
    if (drain_req) run++;
    else begin
      if (run > 0) last_run = run;
      run = 0;
    end
    drain_ack = (ack_delay > 0) && drain_req && (run == ack_delay);
    if (drain_req && !prev_dr) got_q.push_back(drain_fn);
    prev_dr = drain_req;
    for (int f = 0; f < 4; f++) if (cfg_flr_done[f]) done_cnt[f]++;
    if ($countones(fn_reset) > 1) multi = 1'b1;
  endtask

  task automatic clear_log();
    got_q.delete();
    exp_q.delete();
    for (int f = 0; f < 4; f++) done_cnt[f] = 0;
    multi = 1'b0;
    last_run = 0;
  endtask

  task automatic do_reset();
    user_reset = 1'b1;
    cfg_flr_in_process = 4'b0;
    ack_delay = 0;
    drain_ack = 1'b0;
    repeat (3) step();
    user_reset = 1'b0;
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int idle = 0;
    int n = 0;
    while (idle < 3 && n < budget) begin
      step();
      n++;
      if (busy) idle = 0;
      else idle++;
    end
    chk({name, "_quiet_bound"}, 32'(idle >= 3), 32'd1);
  endtask

  // what: 0 = grant count reaches arg, 1 = done seen for fn arg,
  //       2 = fn_reset[arg] high, 3 = drain_req high
  task automatic wait_for(input int what, input int arg, input int budget, input string name);
    bit hit = 1'b0;
    int n = 0;
    while (!hit && n < budget) begin
      step();
      n++;
      case (what)
        0: hit = (got_q.size() >= arg);
        1: hit = (done_cnt[arg] > 0);
        2: hit = fn_reset[arg];
        default: hit = drain_req;
      endcase
    end
    chk({name, "_wait_bound"}, 32'(hit), 32'd1);
  endtask

  task automatic check_grants(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk({name, "_fn"}, (got_q.size() > i) ? 32'(got_q[i]) : 32'hx, 32'(exp_q[i]));
  endtask

  // ---------------- scenarios ----------------
  logic [3:0] s_rst [1:30];
  logic [3:0] s_done[1:30];
  logic       s_dr  [1:30];
  logic [1:0] s_fn  [1:30];
  int         rq[4];

  initial begin
    int first_dr, n_dr, n_dr_fn2, first_rst, n_rst, done_j, n_done, n;
    logic [3:0] done_val;

    user_reset = 1'b1;
    cfg_flr_in_process = 4'b0;
    drain_ack = 1'b0;
    clear_log();
    step();
    check_en = 1'b1;
    step();
    step();
    user_reset = 1'b0;
    chk("reset_outputs", {busy, drain_req, drain_fn, fn_reset, cfg_flr_done, flr_timeout}, 32'd0);

    // single request on fn 2, ack sampled at T0+7
    clear_log();
    ack_delay = 6;
    cfg_flr_in_process[2] = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      step();
      s_dr[j] = drain_req; s_fn[j] = drain_fn; s_rst[j] = fn_reset; s_done[j] = cfg_flr_done;
    end
    first_dr = -1; n_dr = 0; n_dr_fn2 = 0; first_rst = -1; n_rst = 0;
    done_j = -1; n_done = 0; done_val = 4'b0;
    for (int j = 1; j <= 30; j++) begin
      if (s_dr[j]) begin
        n_dr++;
        if (first_dr < 0) first_dr = j;
        if (s_fn[j] == 2'd2) n_dr_fn2++;
      end
      if (s_rst[j] == 4'b0100) begin
        n_rst++;
        if (first_rst < 0) first_rst = j;
      end
      if (s_done[j] != 4'b0) begin
        n_done++; done_j = j; done_val = s_done[j];
      end
    end
    chk("single_first_drain", first_dr, 2);
    chk("single_drain_len", n_dr, 6);
    chk("single_drain_fn", n_dr_fn2, 6);
    chk("single_first_reset", first_rst, 8);
    chk("single_reset_len", n_rst, 16);
    chk("single_done_cycle", done_j, 24);
    chk("single_done_count", n_done, 1);
    chk("single_done_val", done_val, 4'b0100);
    chk("single_timeout", flr_timeout, 4'b0000);
    cfg_flr_in_process = 4'b0;
    repeat (2) step();

    // simultaneous requests 0, 1, 3
    do_reset();
    clear_log();
    ack_delay = 3;
    cfg_flr_in_process = 4'b1011;
    wait_quiet(200, "simul");
    exp_q = '{2'd0, 2'd1, 2'd3};
    check_grants("simul_grants");
    chk("simul_done0", done_cnt[0], 1);
    chk("simul_done1", done_cnt[1], 1);
    chk("simul_done2", done_cnt[2], 0);
    chk("simul_done3", done_cnt[3], 1);
    chk("simul_multihot", multi, 0);
    cfg_flr_in_process = 4'b0;
    repeat (2) step();

    // timeout on fn 1, then a second FLR that is acked
    do_reset();
    clear_log();
    cfg_flr_in_process = 4'b0010;
    wait_quiet(100, "timeout");
    chk("timeout_drain_len", last_run, TO);
    chk("timeout_flag", flr_timeout, 4'b0010);
    chk("timeout_done", done_cnt[1], 1);
    cfg_flr_in_process = 4'b0;
    step();
    clear_log();
    ack_delay = 3;
    cfg_flr_in_process = 4'b0010;
    wait_quiet(100, "timeout2");
    chk("timeout2_drain_len", last_run, 3);
    chk("timeout2_flag_sticky", flr_timeout, 4'b0010);
    chk("timeout2_done", done_cnt[1], 1);
    cfg_flr_in_process = 4'b0;
    repeat (2) step();

    // fairness: fn 0 and fn 2 both re-request right after each done
    do_reset();
    clear_log();
    ack_delay = 3;
    cfg_flr_in_process = 4'b0101;
    for (int f = 0; f < 4; f++) rq[f] = 0;
    n = 0;
    while (got_q.size() < 4 && n < 400) begin
      step();
      n++;
      for (int f = 0; f < 4; f += 2) begin
        if (rq[f] == 1) begin
          cfg_flr_in_process[f] = 1'b1; rq[f] = 0;
        end else if (rq[f] == 2) begin
          cfg_flr_in_process[f] = 1'b0; rq[f] = 1;
        end
        if (cfg_flr_done[f]) rq[f] = 2;
      end
    end
    chk("fair_loop_bound", 32'(got_q.size() >= 4), 32'd1);
    cfg_flr_in_process = 4'b0;
    wait_quiet(100, "fair");
    exp_q = '{2'd0, 2'd2, 2'd0, 2'd2};
    check_grants("fair_grants");

    // abort of a queued request
    do_reset();
    clear_log();
    ack_delay = 3;
    cfg_flr_in_process = 4'b1001;
    wait_for(0, 1, 20, "abort_q_grant");
    cfg_flr_in_process[3] = 1'b0;
    wait_for(1, 0, 60, "abort_q_done");
    step();
    cfg_flr_in_process[0] = 1'b0;
    wait_quiet(100, "abort_q");
    exp_q = '{2'd0};
    check_grants("abort_q_grants");
    chk("abort_q_done0", done_cnt[0], 1);
    chk("abort_q_done3", done_cnt[3], 0);

    // abort of the active function during RESET
    clear_log();
    cfg_flr_in_process[0] = 1'b1;
    wait_for(2, 0, 40, "abort_a_reset");
    cfg_flr_in_process[0] = 1'b0;
    wait_quiet(100, "abort_a");
    exp_q = '{2'd0};
    check_grants("abort_a_grants");
    chk("abort_a_no_done", done_cnt[0], 0);
    chk("abort_a_idle", busy, 1'b0);

    // user_reset during DRAIN, in_process held high across it
    do_reset();
    clear_log();
    cfg_flr_in_process = 4'b0010;
    wait_for(3, 0, 20, "midrst_drain");
    step();
    step();
    user_reset = 1'b1;
    step();
    chk("midrst_outputs", {busy, drain_req, drain_fn, fn_reset, cfg_flr_done, flr_timeout}, 32'd0);
    user_reset = 1'b0;
    ack_delay = 3;
    wait_quiet(100, "midrst");
    exp_q = '{2'd1, 2'd1};
    check_grants("midrst_grants");
    chk("midrst_done", done_cnt[1], 1);
    chk("midrst_timeout", flr_timeout, 4'b0000);
    cfg_flr_in_process = 4'b0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
